// File: rtl/pc_sequencer_if.sv
// Request/response bundle between the fetch controller and pc_sequencer.
// Signal names are from the sequencer's point of view: i_* flow into it, o_* flow out.
interface pc_sequencer_if #(
    parameter int XLEN = 32
);
    logic            i_stall;
    logic            i_branch;
    logic            i_bne;
    logic            i_equal;
    logic [15:0]     i_branch_offset;
    logic            i_jump;
    logic [25:0]     i_jump_target;
    logic            i_jr;
    logic [XLEN-1:0] i_jr_target;
    logic            i_call;
    logic            i_ret;
    logic [XLEN-1:0] o_pc_out;
    logic [XLEN-1:0] o_pc_plus4;
    logic            o_align_err;
    logic            o_ras_empty;

    modport master (
        output i_stall, i_branch, i_bne, i_equal, i_branch_offset,
               i_jump, i_jump_target, i_jr, i_jr_target, i_call, i_ret,
        input  o_pc_out, o_pc_plus4, o_align_err, o_ras_empty
    );

    modport slave (
        input  i_stall, i_branch, i_bne, i_equal, i_branch_offset,
               i_jump, i_jump_target, i_jr, i_jr_target, i_call, i_ret,
        output o_pc_out, o_pc_plus4, o_align_err, o_ras_empty
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: ret > jr > jump > taken branch > pc+4, one-cycle latency.
// Define PC_SEQUENCER_RAS_EN to build the circular return-address stack; otherwise ret acts as jr.
module pc_sequencer #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              RAS_DEPTH    = 4
) (
    input logic           clk,
    input logic           reset,
    pc_sequencer_if.slave bus
);
    logic [XLEN-1:0] r_pc;
    logic            r_alignErr;
    logic [XLEN-1:0] w_pcPlus4;
    logic [XLEN-1:0] w_branchTarget;
    logic [XLEN-1:0] w_jumpTarget;
    logic [XLEN-1:0] w_jrTarget;
    logic [XLEN-1:0] w_nextPc;
    logic            w_taken;
    logic            w_misaligned;
    logic            w_useJr;
    logic            w_alignNext;
    logic            w_pop;
    logic [XLEN-1:0] w_popData;

    assign w_pcPlus4      = r_pc + XLEN'(4);
    assign w_taken        = bus.i_branch & (bus.i_equal ^ bus.i_bne);
    assign w_branchTarget = w_pcPlus4 + {{(XLEN-18){bus.i_branch_offset[15]}}, bus.i_branch_offset, 2'b00};
    assign w_jumpTarget   = {w_pcPlus4[XLEN-1:28], bus.i_jump_target, 2'b00};
    assign w_jrTarget     = {bus.i_jr_target[XLEN-1:2], 2'b00};
    assign w_misaligned   = (bus.i_jr_target[1:0] != 2'b00);

`ifdef PC_SEQUENCER_RAS_EN
    localparam int PTRW = $clog2(RAS_DEPTH);
    localparam int CNTW = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0] r_ras [RAS_DEPTH];
    logic [PTRW-1:0] r_sp;
    logic [CNTW-1:0] r_count;
    logic [PTRW-1:0] w_top;
    logic            w_push;

    // r_sp names the next free slot; a push into a full stack silently overwrites the oldest entry.
    assign w_top     = r_sp - PTRW'(1);
    assign w_popData = r_ras[w_top];
    assign w_pop     = bus.i_ret & (r_count != '0);
    assign w_push    = bus.i_call & (bus.i_jump | bus.i_jr) & ~bus.i_ret;
    assign w_useJr   = (bus.i_ret | bus.i_jr) & ~w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sp    <= '0;
            r_count <= '0;
        end else if (!bus.i_stall) begin
            if (w_pop) begin
                r_sp    <= w_top;
                r_count <= r_count - CNTW'(1);
            end else if (w_push) begin
                r_sp <= r_sp + PTRW'(1);
                if (r_count != CNTW'(RAS_DEPTH)) begin
                    r_count <= r_count + CNTW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!bus.i_stall && w_push) begin
            r_ras[r_sp] <= w_pcPlus4;
        end
    end

    assign bus.o_ras_empty = (r_count == '0);
`else
    logic w_unusedCall;

    assign w_unusedCall    = bus.i_call;
    assign w_pop           = 1'b0;
    assign w_popData       = '0;
    assign w_useJr         = bus.i_ret | bus.i_jr;
    assign bus.o_ras_empty = 1'b1;
`endif

    always_comb begin
        w_nextPc = w_pcPlus4;
        if (w_pop) begin
            w_nextPc = w_popData;
        end else if (w_useJr) begin
            w_nextPc = w_jrTarget;
        end else if (bus.i_jump) begin
            w_nextPc = w_jumpTarget;
        end else if (w_taken) begin
            w_nextPc = w_branchTarget;
        end
    end

    assign w_alignNext = ~bus.i_stall & w_useJr & w_misaligned;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= RESET_VECTOR;
            r_alignErr <= 1'b0;
        end else begin
            r_alignErr <= w_alignNext;
            if (!bus.i_stall) begin
                r_pc <= w_nextPc;
            end
        end
    end

    assign bus.o_pc_out     = r_pc;
    assign bus.o_pc_plus4   = w_pcPlus4;
    assign bus.o_align_err  = r_alignErr;
endmodule
